hash_stream_tbl: RTL and testbench

Responder end of the hash command channel. Accepts find/insert/delete/update commands keyed on a TCP stream 4-tuple and returns one result per command on the hash return channel. The stream table is set-associative and register-based: `NUM_ROWS` rows × `WAYS` ways, with one way compared per cycle. It sits between the TCP stream tracker (the command initiator) and the stream-state consumers, with one command outstanding at a time.

---
 rtl/hash_stream_tbl.sv | 256 +++++++++++++++++++++++++
 tb/tb_hash_stream_tbl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_stream_tbl.sv
// Set-associative stream table answering find/insert/delete/update commands keyed on a TCP 4-tuple.
// Optional occupancy counter port is enabled with `define HASH_OCCUPANCY_EN.

`ifndef HASH_TBL_NUM_ROWS
`define HASH_TBL_NUM_ROWS 16
`endif

package hash_pkg;
    localparam int HASH_ADDR_W = 16;

    typedef enum logic [2:0] {
        CMD_FIND   = 3'd0,
        CMD_INSERT = 3'd1,
        CMD_DELETE = 3'd2,
        CMD_UPDATE = 3'd3
    } hash_cmd_t;

    typedef enum logic [2:0] {
        RET_FOUND        = 3'd0,
        RET_NOT_FOUND    = 3'd1,
        RET_INSERTED     = 3'd2,
        RET_TABLE_FULL   = 3'd3,
        RET_DELETED      = 3'd4,
        RET_UPDATED      = 3'd5,
        RET_INVALID_ADDR = 3'd6
    } hash_ret_t;

    typedef struct packed {
        logic [31:0] ip_1;
        logic [31:0] ip_2;
        logic [15:0] tcp_port_1;
        logic [15:0] tcp_port_2;
    } hash_key_t;

    typedef struct packed {
        logic [7:0] stream_state;
    } hash_data_t;

    typedef struct packed {
        hash_cmd_t               cmd;
        hash_key_t               hashkey;
        hash_data_t              hash_data;
        logic [HASH_ADDR_W-1:0]  hash_node_addr;
    } ch_hash_cmd_data_t;

    typedef struct packed {
        logic              valid;
        ch_hash_cmd_data_t data;
    } ch_hash_cmd_intf_struct;

    typedef struct packed {
        hash_ret_t               hash_ret;
        logic [HASH_ADDR_W-1:0]  hash_node_addr;
        hash_data_t              hash_data;
    } ch_hash_ret_data_t;

    typedef struct packed {
        logic              valid;
        ch_hash_ret_data_t data;
    } ch_hash_ret_intf_struct;
endpackage

// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// the DUT holds ret valid/data stable until its transfer, and ignores cmd valid while ready=0.
module hash_stream_tbl
    import hash_pkg::*;
#(
    parameter int NUM_ROWS = `HASH_TBL_NUM_ROWS,
    parameter int WAYS     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  ch_hash_cmd_intf_struct ch_hash_cmd_intf_in,
    output logic                   ch_hash_cmd_intf_in_ready,
    output ch_hash_ret_intf_struct ch_hash_ret_intf_out,
    input  logic                   ch_hash_ret_intf_out_ready,
`ifdef HASH_OCCUPANCY_EN
    output logic [$clog2(NUM_ROWS*WAYS):0] hash_occupancy,
`endif
    output logic [1:0]             dbg_state
);

    localparam int ENTRIES = NUM_ROWS * WAYS;
    localparam int RW      = $clog2(NUM_ROWS);
    localparam int WW      = $clog2(WAYS);
    localparam int IW      = RW + WW;
    localparam int CW      = $clog2(ENTRIES) + 1;
    localparam logic [31:0] ENTRIES_U = ENTRIES;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            state;
    ch_hash_cmd_data_t cmd_q;
    logic [RW-1:0]     row_q;
    logic [WW-1:0]     way_q;
    logic              free_seen;
    logic [WW-1:0]     free_way;

    logic       ent_valid [ENTRIES];
    hash_key_t  ent_key   [ENTRIES];
    hash_data_t ent_data  [ENTRIES];

    function automatic logic [RW-1:0] row_hash(input hash_key_t k);
        return RW'(k.ip_1 ^ k.ip_2 ^ {16'd0, k.tcp_port_1} ^ {16'd0, k.tcp_port_2});
    endfunction

    logic [RW-1:0] cmd_row;
    logic [IW-1:0] scan_idx, ins_idx, row_base, exec_idx;
    logic          scan_match, scan_free, scan_last;
    logic          addr_ok, exec_hit;
    logic          ins_fire, del_fire, upd_fire;

    assign cmd_row    = row_hash(ch_hash_cmd_intf_in.data.hashkey);
    assign scan_idx   = {row_q, way_q};
    assign row_base   = {row_q, {WW{1'b0}}};
    assign ins_idx    = {row_q, (free_seen ? free_way : way_q)};
    assign scan_match = ent_valid[scan_idx] && (ent_key[scan_idx] == cmd_q.hashkey);
    assign scan_free  = !ent_valid[scan_idx];
    assign scan_last  = (way_q == WW'(WAYS - 1));

    assign addr_ok  = (32'(cmd_q.hash_node_addr) < ENTRIES_U);
    assign exec_idx = cmd_q.hash_node_addr[IW-1:0];
    assign exec_hit = addr_ok && ent_valid[exec_idx];

    // Free way is the lowest one seen so far; the current way counts only on the last compare.
    assign ins_fire = (state == S_SCAN) && !scan_match && scan_last &&
                      (cmd_q.cmd == CMD_INSERT) && (free_seen || scan_free);
    assign del_fire = (state == S_EXEC) && (cmd_q.cmd == CMD_DELETE) && exec_hit;
    assign upd_fire = (state == S_EXEC) && (cmd_q.cmd == CMD_UPDATE) && exec_hit;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                     <= S_IDLE;
            ch_hash_cmd_intf_in_ready <= 1'b0;
            ch_hash_ret_intf_out      <= '0;
            cmd_q                     <= '0;
            row_q                     <= '0;
            way_q                     <= '0;
            free_seen                 <= 1'b0;
            free_way                  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_valid[i] <= 1'b0;
                ent_key[i]   <= '0;
                ent_data[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (ch_hash_cmd_intf_in.valid && ch_hash_cmd_intf_in_ready) begin
                        ch_hash_cmd_intf_in_ready <= 1'b0;
                        cmd_q     <= ch_hash_cmd_intf_in.data;
                        row_q     <= cmd_row;
                        way_q     <= '0;
                        free_seen <= 1'b0;
                        free_way  <= '0;
                        // Unknown encodings take the one-cycle path and answer invalid_addr.
                        if (ch_hash_cmd_intf_in.data.cmd == CMD_FIND ||
                            ch_hash_cmd_intf_in.data.cmd == CMD_INSERT)
                            state <= S_SCAN;
                        else
                            state <= S_EXEC;
                    end else begin
                        ch_hash_cmd_intf_in_ready <= 1'b1;
                    end
                end

                S_SCAN: begin
                    if (scan_match) begin
                        ch_hash_ret_intf_out.valid               <= 1'b1;
                        ch_hash_ret_intf_out.data.hash_ret       <= RET_FOUND;
                        ch_hash_ret_intf_out.data.hash_node_addr <= HASH_ADDR_W'(scan_idx);
                        ch_hash_ret_intf_out.data.hash_data      <= ent_data[scan_idx];
                        state <= S_RESP;
                    end else if (scan_last) begin
                        ch_hash_ret_intf_out.valid <= 1'b1;
                        state <= S_RESP;
                        if (ins_fire) begin
                            ent_valid[ins_idx] <= 1'b1;
                            ent_key[ins_idx]   <= cmd_q.hashkey;
                            ent_data[ins_idx]  <= cmd_q.hash_data;
                            ch_hash_ret_intf_out.data.hash_ret       <= RET_INSERTED;
                            ch_hash_ret_intf_out.data.hash_node_addr <= HASH_ADDR_W'(ins_idx);
                            ch_hash_ret_intf_out.data.hash_data      <= cmd_q.hash_data;
                        end else begin
                            ch_hash_ret_intf_out.data.hash_ret <=
                                (cmd_q.cmd == CMD_INSERT) ? RET_TABLE_FULL : RET_NOT_FOUND;
                            ch_hash_ret_intf_out.data.hash_node_addr <= HASH_ADDR_W'(row_base);
                            ch_hash_ret_intf_out.data.hash_data      <= '0;
                        end
                    end else begin
                        if (scan_free && !free_seen) begin
                            free_seen <= 1'b1;
                            free_way  <= way_q;
                        end
                        way_q <= way_q + WW'(1);
                    end
                end

                S_EXEC: begin
                    ch_hash_ret_intf_out.valid               <= 1'b1;
                    ch_hash_ret_intf_out.data.hash_node_addr <= cmd_q.hash_node_addr;
                    ch_hash_ret_intf_out.data.hash_data      <= '0;
                    state <= S_RESP;
                    if (cmd_q.cmd != CMD_DELETE && cmd_q.cmd != CMD_UPDATE) begin
                        ch_hash_ret_intf_out.data.hash_ret <= RET_INVALID_ADDR;
                    end else if (!addr_ok) begin
                        ch_hash_ret_intf_out.data.hash_ret <= RET_INVALID_ADDR;
                    end else if (!exec_hit) begin
                        ch_hash_ret_intf_out.data.hash_ret <= RET_NOT_FOUND;
                    end else if (del_fire) begin
                        ent_valid[exec_idx] <= 1'b0;
                        ch_hash_ret_intf_out.data.hash_ret  <= RET_DELETED;
                        ch_hash_ret_intf_out.data.hash_data <= ent_data[exec_idx];
                    end else if (upd_fire) begin
                        ent_data[exec_idx] <= cmd_q.hash_data;
                        ch_hash_ret_intf_out.data.hash_ret  <= RET_UPDATED;
                        ch_hash_ret_intf_out.data.hash_data <= cmd_q.hash_data;
                    end
                end

                S_RESP: begin
                    if (ch_hash_ret_intf_out_ready) begin
                        ch_hash_ret_intf_out.valid <= 1'b0;
                        ch_hash_cmd_intf_in_ready  <= 1'b1;
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HASH_OCCUPANCY_EN
    logic [CW-1:0] occ_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            occ_q <= '0;
        else if (ins_fire)
            occ_q <= occ_q + CW'(1);
        else if (del_fire)
            occ_q <= occ_q - CW'(1);
    end

    assign hash_occupancy = occ_q;
`endif

endmodule

// File: tb/tb_hash_stream_tbl.sv
// Bench for hash_stream_tbl: directed vector table, backpressure and reset corners, then random
// commands scored against an array-based model of the table.
module tb_hash_stream_tbl;
    import hash_pkg::*;

    localparam int NUM_ROWS = 16;
    localparam int WAYS     = 4;
    localparam int ENTRIES  = NUM_ROWS * WAYS;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    ch_hash_cmd_intf_struct cmd_in;
    logic                   cmd_ready;
    ch_hash_ret_intf_struct ret_out;
    logic                   ret_ready;
    logic [1:0]             dbg_state;
`ifdef HASH_OCCUPANCY_EN
    logic [6:0]             occ;
`endif

    hash_stream_tbl #(.NUM_ROWS(NUM_ROWS), .WAYS(WAYS)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .ch_hash_cmd_intf_in        (cmd_in),
        .ch_hash_cmd_intf_in_ready  (cmd_ready),
        .ch_hash_ret_intf_out       (ret_out),
        .ch_hash_ret_intf_out_ready (ret_ready),
`ifdef HASH_OCCUPANCY_EN
        .hash_occupancy             (occ),
`endif
        .dbg_state                  (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_vec  = 0;
    int n_miss = 0;
    logic [26:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         m_valid [ENTRIES];
    hash_key_t  m_key   [ENTRIES];
    logic [7:0] m_data  [ENTRIES];
    int         m_occ;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_key[i]   = '0;
            m_data[i]  = '0;
        end
        m_occ = 0;
    endfunction

    function automatic void model_cmd(input hash_cmd_t c, input hash_key_t k, input logic [7:0] d,
                                      input logic [15:0] a, output hash_ret_t r,
                                      output logic [15:0] ra, output logic [7:0] rd, output int lat);
        int row, hit, free, ai;
        row = int'((k.ip_1 ^ k.ip_2 ^ {16'd0, k.tcp_port_1} ^ {16'd0, k.tcp_port_2}) % NUM_ROWS);
        ai  = int'(a);
        rd  = 8'd0;
        if (c == CMD_FIND || c == CMD_INSERT) begin
            hit = -1;
            free = -1;
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[row*WAYS+w] && m_key[row*WAYS+w] == k && hit < 0) hit = w;
                if (!m_valid[row*WAYS+w] && free < 0) free = w;
            end
            if (hit >= 0) begin
                r = RET_FOUND; ra = 16'(row*WAYS+hit); rd = m_data[row*WAYS+hit]; lat = hit + 1;
            end else begin
                lat = WAYS;
                ra  = 16'(row*WAYS);
                if (c == CMD_FIND) r = RET_NOT_FOUND;
                else if (free < 0) r = RET_TABLE_FULL;
                else begin
                    m_valid[row*WAYS+free] = 1'b1;
                    m_key[row*WAYS+free]   = k;
                    m_data[row*WAYS+free]  = d;
                    m_occ++;
                    r = RET_INSERTED; ra = 16'(row*WAYS+free); rd = d;
                end
            end
        end else if (c == CMD_DELETE || c == CMD_UPDATE) begin
            lat = 1;
            ra  = a;
            if (ai >= ENTRIES) r = RET_INVALID_ADDR;
            else if (!m_valid[ai]) r = RET_NOT_FOUND;
            else if (c == CMD_DELETE) begin
                m_valid[ai] = 1'b0; m_occ--; r = RET_DELETED; rd = m_data[ai];
            end else begin
                m_data[ai] = d; r = RET_UPDATED; rd = d;
            end
        end else begin
            lat = 1; ra = a; r = RET_INVALID_ADDR;
        end
    endfunction

    function automatic hash_key_t mk_key(input logic [31:0] a, input logic [31:0] b,
                                         input logic [15:0] p, input logic [15:0] q);
        hash_key_t k;
        k.ip_1 = a; k.ip_2 = b; k.tcp_port_1 = p; k.tcp_port_2 = q;
        return k;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_cmd(input hash_cmd_t c, input hash_key_t k, input logic [7:0] d,
                             input logic [15:0] a);
        cmd_in.valid                        = 1'b1;
        cmd_in.data.cmd                     = c;
        cmd_in.data.hashkey                 = k;
        cmd_in.data.hash_data.stream_state  = d;
        cmd_in.data.hash_node_addr          = a;
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send_cmd(input hash_cmd_t c, input hash_key_t k, input logic [7:0] d,
                            input logic [15:0] a, output bit ok);
        int n = 0;
        ok = 1'b0;
        drive_cmd(c, k, d, a);
        while (!ok && n < 40) begin
            if (cmd_ready) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        cmd_in.valid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ret(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (!ok && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ret_out.valid) ok = 1'b1;
        end
        if (!ok) chk("ret_timeout", 32'd0, 32'd1);
    endtask

    task automatic hold_ret(input int n, input ch_hash_ret_data_t cap);
        ret_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(ret_out.valid), 32'd1);
            chk("hold_data", 32'(ret_out.data), 32'(cap));
            chk("hold_ready", 32'(cmd_ready), 32'd0);
        end
    endtask

    task automatic ret_handshake();
        ret_ready = 1'b1;
        @(posedge clk); #1;
        ret_ready = 1'b0;
        chk("ret_valid_after_hs", 32'(ret_out.valid), 32'd0);
        chk("ready_after_hs", 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_one(input hash_cmd_t c, input hash_key_t k, input logic [7:0] d,
                           input logic [15:0] a, input int hold,
                           output ch_hash_ret_data_t got, output int lat, output bit ok);
        got = '0;
        lat = 0;
        send_cmd(c, k, d, a, ok);
        if (ok) wait_ret(lat, ok);
        if (ok) begin
            got = ret_out.data;
            hold_ret(hold, got);
            ret_handshake();
        end
    endtask

    task automatic chk_occ(input string name, input int exp);
`ifdef HASH_OCCUPANCY_EN
        chk(name, 32'(occ), 32'(exp));
`else
        n_vec = n_vec + 0;
        if (exp < 0) $display("negative occupancy in model: %0d", exp);
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        hash_cmd_t  cmd;
        hash_key_t  key;
        logic [7:0] data;
        logic [15:0] addr;
        hash_ret_t  exp_ret;
        logic [15:0] exp_addr;
        logic [7:0] exp_data;
        int         exp_lat;
        int         exp_occ;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input hash_cmd_t c, input hash_key_t k, input logic [7:0] d,
                                input logic [15:0] a, input hash_ret_t er, input logic [15:0] ea,
                                input logic [7:0] ed, input int el, input int eo);
        vec_t v;
        v.cmd = c; v.key = k; v.data = d; v.addr = a;
        v.exp_ret = er; v.exp_addr = ea; v.exp_data = ed; v.exp_lat = el; v.exp_occ = eo;
        return v;
    endfunction

    hash_key_t k0, k1, k2, k3, k4, k5;
    hash_key_t pool [20];

    initial begin
        ch_hash_ret_data_t got, cap;
        hash_ret_t  mr;
        logic [15:0] ma;
        logic [7:0]  md;
        int lat, mlat, sel;
        bit ok;
        logic [26:0] e;
        hash_cmd_t rc;
        logic [15:0] raddr;

        cmd_in    = '0;
        ret_ready = 1'b0;
        model_reset();

        k0 = mk_key(32'h56, 32'h57, 16'h58, 16'h59);
        k1 = mk_key(32'h101, 32'h101, 16'h0, 16'h0);
        k2 = mk_key(32'h102, 32'h102, 16'h0, 16'h0);
        k3 = mk_key(32'h103, 32'h103, 16'h0, 16'h0);
        k4 = mk_key(32'h104, 32'h104, 16'h0, 16'h0);
        k5 = mk_key(32'h105, 32'h105, 16'h0, 16'h0);

        tbl[0]  = mk(CMD_FIND,   k0, 8'h00, 16'd0,  RET_NOT_FOUND,    16'd0,  8'h00, 4, 0);
        tbl[1]  = mk(CMD_INSERT, k0, 8'h03, 16'd0,  RET_INSERTED,     16'd0,  8'h03, 4, 1);
        tbl[2]  = mk(CMD_FIND,   k0, 8'h00, 16'd0,  RET_FOUND,        16'd0,  8'h03, 1, 1);
        tbl[3]  = mk(CMD_INSERT, k0, 8'h09, 16'd0,  RET_FOUND,        16'd0,  8'h03, 1, 1);
        tbl[4]  = mk(CMD_INSERT, k1, 8'h11, 16'd0,  RET_INSERTED,     16'd1,  8'h11, 4, 2);
        tbl[5]  = mk(CMD_INSERT, k2, 8'h12, 16'd0,  RET_INSERTED,     16'd2,  8'h12, 4, 3);
        tbl[6]  = mk(CMD_INSERT, k3, 8'h13, 16'd0,  RET_INSERTED,     16'd3,  8'h13, 4, 4);
        tbl[7]  = mk(CMD_INSERT, k4, 8'h14, 16'd0,  RET_TABLE_FULL,   16'd0,  8'h00, 4, 4);
        tbl[8]  = mk(CMD_FIND,   k3, 8'h00, 16'd0,  RET_FOUND,        16'd3,  8'h13, 4, 4);
        tbl[9]  = mk(CMD_DELETE, k0, 8'h00, 16'd1,  RET_DELETED,      16'd1,  8'h11, 1, 3);
        tbl[10] = mk(CMD_INSERT, k5, 8'h15, 16'd0,  RET_INSERTED,     16'd1,  8'h15, 4, 4);
        tbl[11] = mk(CMD_DELETE, k0, 8'h00, 16'd2,  RET_DELETED,      16'd2,  8'h12, 1, 3);
        tbl[12] = mk(CMD_DELETE, k0, 8'h00, 16'd2,  RET_NOT_FOUND,    16'd2,  8'h00, 1, 3);
        tbl[13] = mk(CMD_DELETE, k0, 8'h00, 16'd64, RET_INVALID_ADDR, 16'd64, 8'h00, 1, 3);
        tbl[14] = mk(CMD_UPDATE, k0, 8'h33, 16'd3,  RET_UPDATED,      16'd3,  8'h33, 1, 3);
        tbl[15] = mk(CMD_FIND,   k3, 8'h00, 16'd0,  RET_FOUND,        16'd3,  8'h33, 4, 3);
        tbl[16] = mk(CMD_UPDATE, k0, 8'h44, 16'd2,  RET_NOT_FOUND,    16'd2,  8'h00, 1, 3);
        tbl[17] = mk(hash_cmd_t'(3'd5), k0, 8'h00, 16'd1, RET_INVALID_ADDR, 16'd1, 8'h00, 1, 3);
        tbl[18] = mk(CMD_INSERT, k2, 8'h22, 16'd0,  RET_INSERTED,     16'd2,  8'h22, 4, 4);

        // ---- reset state ----
        #12;
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_ret_valid", 32'(ret_out.valid), 32'd0);
        chk("rst_ret_data", 32'(ret_out.data), 32'd0);
        chk_occ("rst_occ", 0);
        #1 reset = 1'b1;
        #1 chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'(cmd_ready), 32'd1);

        // ---- directed table ----
        for (int i = 0; i < 19; i++) begin
            model_cmd(tbl[i].cmd, tbl[i].key, tbl[i].data, tbl[i].addr, mr, ma, md, mlat);
            run_one(tbl[i].cmd, tbl[i].key, tbl[i].data, tbl[i].addr, i % 3, got, lat, ok);
            if (ok) begin
                chk($sformatf("tbl%0d_ret", i), 32'(got.hash_ret), 32'(tbl[i].exp_ret));
                chk($sformatf("tbl%0d_addr", i), 32'(got.hash_node_addr), 32'(tbl[i].exp_addr));
                chk($sformatf("tbl%0d_data", i), 32'(got.hash_data), 32'(tbl[i].exp_data));
                chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
                chk_occ($sformatf("tbl%0d_occ", i), tbl[i].exp_occ);
            end
        end

        // ---- backpressure with a competing command ----
        model_cmd(CMD_FIND, k0, 8'h00, 16'd0, mr, ma, md, mlat);
        send_cmd(CMD_FIND, k0, 8'h00, 16'd0, ok);
        if (ok) wait_ret(lat, ok);
        if (ok) begin
            cap = ret_out.data;
            chk("bp_first", 32'(cap), 32'({mr, ma, md}));
            drive_cmd(CMD_FIND, k3, 8'h00, 16'd0);
            hold_ret(10, cap);
            ret_ready = 1'b1;
            @(posedge clk); #1;
            ret_ready = 1'b0;
            chk("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
            chk("bp_valid_after_hs", 32'(ret_out.valid), 32'd0);
            @(posedge clk); #1;
            cmd_in.valid = 1'b0;
            chk("bp_second_accepted", 32'(cmd_ready), 32'd0);
            model_cmd(CMD_FIND, k3, 8'h00, 16'd0, mr, ma, md, mlat);
            wait_ret(lat, ok);
            if (ok) begin
                chk("bp_second_ret", 32'(ret_out.data), 32'({mr, ma, md}));
                chk("bp_second_lat", 32'(lat), 32'(mlat));
                ret_handshake();
            end
        end

        // ---- reset in the 2nd cycle of a find ----
        send_cmd(CMD_FIND, k3, 8'h00, 16'd0, ok);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_ret_valid", 32'(ret_out.valid), 32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
        chk_occ("mid_rst_occ", 0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_hold_valid", 32'(ret_out.valid), 32'd0);
        end
        #2 reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_mid_rst", 32'(cmd_ready), 32'd1);
        run_one(CMD_FIND, k0, 8'h00, 16'd0, 0, got, lat, ok);
        if (ok) begin
            chk("post_rst_find", 32'(got), 32'({RET_NOT_FOUND, 16'd0, 8'h00}));
            chk("post_rst_lat", 32'(lat), 32'd4);
        end

        // ---- randomized commands against the model ----
        for (int i = 0; i < 20; i++) begin
            pool[i].ip_1       = $urandom;
            pool[i].ip_2       = pool[i].ip_1 ^ 32'($urandom_range(0, 2));
            pool[i].tcp_port_1 = 16'($urandom_range(0, 65535));
            pool[i].tcp_port_2 = pool[i].tcp_port_1;
        end
        for (int i = 0; i < 200; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel <= 2) rc = CMD_FIND;
            else if (sel <= 5) rc = CMD_INSERT;
            else if (sel <= 7) rc = CMD_DELETE;
            else if (sel == 8) rc = CMD_UPDATE;
            else rc = hash_cmd_t'(3'(4 + $urandom_range(0, 3)));
            raddr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 200))
                                                : 16'($urandom_range(0, 11));
            md = 8'($urandom_range(0, 255));
            sel = int'($urandom_range(0, 19));
            model_cmd(rc, pool[sel], md, raddr, mr, ma, e[7:0], mlat);
            exp_q.push_back({mr, ma, e[7:0]});
            run_one(rc, pool[sel], md, raddr, int'($urandom_range(0, 3)), got, lat, ok);
            e = exp_q.pop_front();
            if (ok) begin
                chk($sformatf("rand%0d_ret", i), 32'(got), 32'(e));
                chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(mlat));
                chk_occ($sformatf("rand%0d_occ", i), m_occ);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
